// File: rtl/slime_pkg.sv
// ============================================================================
//  Module   : slime_pkg
//  Purpose  : Shared slime motion types, keycodes and field limits.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package slime_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } actor_state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP  = 8'h1A;

  // Playfield extents, shared with the puck block.
  localparam int unsigned FIELD_X_MAX = 639;
  localparam int unsigned FIELD_Y_MAX = 479;

endpackage

`default_nettype wire

// File: rtl/slime_actor_key_decode.sv
// ============================================================================
//  Module   : actor_key_decode
//  Purpose  : Combinational HID keycode to left/right/jump decoder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module actor_key_decode
  import slime_pkg::*;
(
  input  logic [7:0] keycode,
  output logic       left,
  output logic       right,
  output logic       jump
);

  assign left  = (keycode == KEY_LEFT);
  assign right = (keycode == KEY_RIGHT);
  assign jump  = (keycode == KEY_JUMP);

endmodule

`default_nettype wire

// File: rtl/slime_actor.sv
// ============================================================================
//  Module   : slime_actor
//  Purpose  : Per-frame slime motion: horizontal steps, gravity jump, clamping.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module slime_actor
  import slime_pkg::*;
#(
  parameter int unsigned X_START  = 320,
  parameter int unsigned Y_GROUND = 440,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = FIELD_X_MAX,
  parameter int unsigned Y_MIN    = 0,
  parameter int unsigned SIZE     = 40,
  parameter int unsigned STEP_X   = 6,
  parameter int unsigned JUMP_V   = 16,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned MAX_FALL = 16
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       GameActive,
  output logic [9:0] Actor_X,
  output logic [9:0] Actor_Y,
  output logic [9:0] Actor_Size,
  output logic       airborne
);

  localparam logic [10:0] C_X_LO     = 11'(X_MIN + SIZE);
  localparam logic [10:0] C_X_HI     = 11'(X_MAX - SIZE);
  localparam logic [10:0] C_Y_LO     = 11'(Y_MIN + SIZE);
  localparam logic [10:0] C_Y_GND    = 11'(Y_GROUND);
  localparam logic [10:0] C_STEP     = 11'(STEP_X);
  localparam logic [4:0]  C_JUMP_V   = 5'(JUMP_V);
  localparam logic [4:0]  C_GRAV     = 5'(GRAVITY);
  localparam logic [5:0]  C_MAX_FALL = 6'(MAX_FALL);

  actor_state_t r_state, w_state_nxt;
  logic [9:0]   r_x, r_y, w_x_nxt, w_y_nxt;
  logic [4:0]   r_vy, w_vy_nxt, w_vy_rise;
  logic [5:0]   w_vy_sum, w_vy_fall;
  logic [10:0]  w_x_ext, w_y_ext, w_vy_ext;
  logic [10:0]  w_x_dn, w_x_up, w_y_up, w_y_dn;
  logic         w_left, w_right, w_jump;

  actor_key_decode u_key_decode (
    .keycode (keycode),
    .left    (w_left),
    .right   (w_right),
    .jump    (w_jump)
  );

  // 11-bit arithmetic; bit 10 of a difference flags an underflow past zero.
  assign w_x_ext   = {1'b0, r_x};
  assign w_y_ext   = {1'b0, r_y};
  assign w_vy_ext  = {6'd0, r_vy};
  assign w_x_dn    = w_x_ext - C_STEP;
  assign w_x_up    = w_x_ext + C_STEP;
  assign w_y_up    = w_y_ext - w_vy_ext;
  assign w_vy_rise = (r_vy > C_GRAV) ? (r_vy - C_GRAV) : 5'd0;
  assign w_vy_sum  = {1'b0, r_vy} + {1'b0, C_GRAV};
  assign w_vy_fall = (w_vy_sum > C_MAX_FALL) ? C_MAX_FALL : w_vy_sum;
  assign w_y_dn    = w_y_ext + {5'd0, w_vy_fall};

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_vy_nxt    = r_vy;
    if (GameActive) begin
      if (w_left) begin
        w_x_nxt = (w_x_dn[10] || (w_x_dn < C_X_LO)) ? C_X_LO[9:0] : w_x_dn[9:0];
      end else if (w_right) begin
        w_x_nxt = (w_x_up > C_X_HI) ? C_X_HI[9:0] : w_x_up[9:0];
      end
      case (r_state)
        GROUND: begin
          if (w_jump) begin
            w_state_nxt = RISE;
            w_vy_nxt    = C_JUMP_V;
          end
        end
        RISE: begin
          if (w_y_up[10] || (w_y_up < C_Y_LO)) begin
            w_y_nxt     = C_Y_LO[9:0];
            w_vy_nxt    = 5'd0;
            w_state_nxt = FALL;
          end else begin
            w_y_nxt  = w_y_up[9:0];
            w_vy_nxt = w_vy_rise;
            if (w_vy_rise == 5'd0) w_state_nxt = FALL;
          end
        end
        FALL: begin
          if (w_y_dn >= C_Y_GND) begin
            w_y_nxt     = C_Y_GND[9:0];
            w_vy_nxt    = 5'd0;
            w_state_nxt = GROUND;
          end else begin
            w_y_nxt  = w_y_dn[9:0];
            w_vy_nxt = w_vy_fall[4:0];
          end
        end
        default: begin
          w_state_nxt = GROUND;
          w_vy_nxt    = 5'd0;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= GROUND;
      r_x     <= 10'(X_START);
      r_y     <= 10'(Y_GROUND);
      r_vy    <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_vy    <= w_vy_nxt;
    end
  end

  assign Actor_X    = r_x;
  assign Actor_Y    = r_y;
  assign Actor_Size = 10'(SIZE);
  assign airborne   = (r_state != GROUND);

endmodule

`default_nettype wire

// File: tb/tb_slime_actor.sv
// ============================================================================
//  Module   : tb_slime_actor
//  Purpose  : Self-checking bench for slime_actor against a behavioural model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_slime_actor;

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic [7:0] keycode;
  logic       GameActive;
  logic [9:0] Actor_X, Actor_Y, Actor_Size;
  logic       airborne;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: signed velocity, negative means moving up.
  int m_x, m_y, m_vel;
  bit m_air;

  slime_actor dut (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .keycode    (keycode),
    .GameActive (GameActive),
    .Actor_X    (Actor_X),
    .Actor_Y    (Actor_Y),
    .Actor_Size (Actor_Size),
    .airborne   (airborne)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 320; m_y = 440; m_vel = 0; m_air = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] k, input logic act);
    if (act) begin
      if (k == 8'h04)      m_x = (m_x - 6 < 40)  ? 40  : m_x - 6;
      else if (k == 8'h07) m_x = (m_x + 6 > 599) ? 599 : m_x + 6;
      if (!m_air) begin
        if (k == 8'h1A) begin m_air = 1'b1; m_vel = -16; end
      end else if (m_vel < 0) begin
        if (m_y + m_vel < 40) begin m_y = 40; m_vel = 0; end
        else begin m_y = m_y + m_vel; m_vel = m_vel + 1; end
      end else begin
        m_vel = (m_vel + 1 > 16) ? 16 : m_vel + 1;
        if (m_y + m_vel >= 440) begin m_y = 440; m_vel = 0; m_air = 1'b0; end
        else m_y = m_y + m_vel;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".x"},    int'(Actor_X),    m_x);
    check({tag, ".y"},    int'(Actor_Y),    m_y);
    check({tag, ".air"},  int'(airborne),   int'(m_air));
    check({tag, ".size"}, int'(Actor_Size), 40);
  endtask

  task automatic frame(input logic [7:0] k, input logic act, input string tag);
    keycode = k; GameActive = act;
    @(posedge frame_clk);
    model_step(k, act);
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #1 Reset_n = 1'b0;
    #1 model_reset();
    compare_all(tag);
    check({tag, ".x_abs"}, int'(Actor_X), 320);
    check({tag, ".y_abs"}, int'(Actor_Y), 440);
    #1 Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0; keycode = 8'h00; GameActive = 1'b1;
    model_reset();
    #12;
    compare_all("reset");
    Reset_n = 1'b1;

    // Full jump arc from a one-frame jump key.
    frame(8'h1A, 1'b1, "jump_k");
    check("jump_k.y_abs", int'(Actor_Y), 440);
    for (int i = 1; i <= 32; i++) begin
      frame(8'h00, 1'b1, "arc");
      if (i == 1)  check("arc.k1_y",    int'(Actor_Y), 424);
      if (i == 16) check("arc.apex_y",  int'(Actor_Y), 304);
      if (i == 31) check("arc.k31_air", int'(airborne), 1);
      if (i == 32) begin
        check("arc.land_y",   int'(Actor_Y),  440);
        check("arc.land_air", int'(airborne), 0);
      end
    end

    // Right clamp: 320 -> 590 -> 596 -> 599 -> 599.
    for (int i = 0; i < 45; i++) frame(8'h07, 1'b1, "right_run");
    check("right.590", int'(Actor_X), 590);
    frame(8'h07, 1'b1, "right"); check("right.596", int'(Actor_X), 596);
    frame(8'h07, 1'b1, "right"); check("right.599", int'(Actor_X), 599);
    frame(8'h07, 1'b1, "right"); check("right.hold", int'(Actor_X), 599);

    // Left clamp, then from 46 -> 40 -> 40.
    for (int i = 0; i < 100; i++) frame(8'h04, 1'b1, "left_run");
    check("left.clamp", int'(Actor_X), 40);
    frame(8'h07, 1'b1, "left"); check("left.46",   int'(Actor_X), 46);
    frame(8'h04, 1'b1, "left"); check("left.40",   int'(Actor_X), 40);
    frame(8'h04, 1'b1, "left"); check("left.hold", int'(Actor_X), 40);

    // Unknown keycode gives no motion.
    for (int i = 0; i < 3; i++) frame(8'h2C, 1'b1, "nokey");
    check("nokey.x", int'(Actor_X), 40);
    check("nokey.y", int'(Actor_Y), 440);

    // Freeze mid-rise, then resume and land on the original schedule.
    frame(8'h1A, 1'b1, "frz_jump");
    for (int i = 0; i < 6; i++) frame(8'h00, 1'b1, "frz_rise");
    check("frz.y_before", int'(Actor_Y), 359);
    for (int i = 0; i < 10; i++) begin
      frame(8'(($urandom_range(0, 3) == 0) ? 8'h1A : 8'h07), 1'b0, "frz_hold");
      check("frz.y_held", int'(Actor_Y), 359);
    end
    for (int i = 1; i <= 26; i++) begin
      frame(8'h00, 1'b1, "frz_resume");
      if (i == 25) check("frz.air_25", int'(airborne), 1);
      if (i == 26) begin
        check("frz.land_y",   int'(Actor_Y),  440);
        check("frz.land_air", int'(airborne), 0);
      end
    end

    // Asynchronous reset while falling.
    frame(8'h1A, 1'b1, "ar_jump");
    for (int i = 0; i < 20; i++) frame(8'h00, 1'b1, "ar_arc");
    check("ar.y_fall", int'(Actor_Y), 314);
    async_reset("ar");
    frame(8'h00, 1'b1, "ar_after");

    // Held jump re-triggers on the frame after landing.
    frame(8'h1A, 1'b1, "hold_k");
    for (int i = 1; i <= 33; i++) begin
      frame(8'h1A, 1'b1, "hold");
      if (i == 32) check("hold.land_air", int'(airborne), 0);
      if (i == 33) begin
        check("hold.retrig_air", int'(airborne), 1);
        check("hold.retrig_y",   int'(Actor_Y),  440);
      end
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] k;
      logic       act;
      case ($urandom_range(0, 5))
        0:       k = 8'h04;
        1:       k = 8'h07;
        2, 3:    k = 8'h1A;
        4:       k = 8'h00;
        default: k = 8'($urandom_range(0, 255));
      endcase
      act = ($urandom_range(0, 9) != 0);
      frame(k, act, "rand");
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
